// File: rtl/ps2_pkg.sv
// ps2_pkg: scan codes and FSM encodings shared by the PS/2 arrow-key front end.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_EXT,
        C_BRK,
        C_EXTBRK
    } code_state_t;

    // One-hot {up, down, left, right}; zero for non-arrow codes.
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] m;
        m = 4'b0000;
        unique case (1'b1)
            (code == SC_UP):    m = 4'b1000;
            (code == SC_DOWN):  m = 4'b0100;
            (code == SC_LEFT):  m = 4'b0010;
            (code == SC_RIGHT): m = 4'b0001;
            default:            m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 line conditioning and 11-bit frame deframer.
// Odd-parity rejection is built only when PS2_PARITY_CHK_EN is defined.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_s;
    logic [1:0]    dat_s;
    logic          filt;
    logic          filt_d;
    logic [FW-1:0] fcnt;
    logic          fall;
    logic          din;

    frame_state_t  state, state_n;
    logic [7:0]    shift;
    logic [2:0]    bcnt;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic          par_ok;
    logic          shift_en;
    logic          accept;
    logic          err;

    assign fall = filt_d & ~filt;
    assign din  = dat_s[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s  <= 2'b11;
            dat_s  <= 2'b11;
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
        end else begin
            clk_s  <= {clk_s[0], ps2_clk};
            dat_s  <= {dat_s[0], ps2_data};
            filt_d <= filt;
            if (clk_s[1] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt <= clk_s[1];
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

`ifdef PS2_PARITY_CHK_EN
    logic par;
    assign par_ok = ^{shift, par};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par <= 1'b0;
        end else if (fall && state == PARITY) begin
            par <= din;
        end
    end
`else
    assign par_ok = 1'b1;
`endif

    assign timeout = (state != IDLE) && !fall &&
                     (tcnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_n  = state;
        shift_en = 1'b0;
        accept   = 1'b0;
        err      = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    if (!din) state_n = DATA;
                    else      err     = 1'b1;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bcnt == 3'd7) state_n = PARITY;
                end
            end
            PARITY: begin
                if (fall) state_n = STOP;
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    if (din && par_ok) accept = 1'b1;
                    else               err    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            state_n = IDLE;
            err     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift      <= 8'h00;
            bcnt       <= 3'd0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            byte_valid <= accept;
            frame_err  <= err;
            if (shift_en) begin
                shift <= {din, shift[7:1]};
                bcnt  <= bcnt + 3'd1;
            end else if (state == IDLE) begin
                bcnt <= 3'd0;
            end
            if (accept) byte_data <= shift;
            if (fall || timeout || state == IDLE) tcnt <= '0;
            else                                  tcnt <= tcnt + TW'(1);
        end
    end

endmodule

// File: rtl/ps2_arrow_keys.sv
// ps2_arrow_keys: PS/2 arrow-key decoder feeding the Tetris VGA controller.
// Optional parity rejection via PS2_PARITY_CHK_EN (in ps2_rx_frame).
module ps2_arrow_keys
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ    = 25000000,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = CLK_FREQ / 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       up_p,
    output logic       down_p,
    output logic       left_p,
    output logic       right_p,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    code_state_t cs, cs_n;
    logic [3:0]  lvl, lvl_n;
    logic [3:0]  pls;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    always_comb begin
        cs_n  = cs;
        lvl_n = lvl;
        if (byte_valid) begin
            unique case (cs)
                C_IDLE: begin
                    if (byte_data == SC_EXT)      cs_n = C_EXT;
                    else if (byte_data == SC_BRK) cs_n = C_BRK;
                end
                C_EXT: begin
                    if (byte_data == SC_BRK) begin
                        cs_n = C_EXTBRK;
                    end else if (byte_data != SC_EXT) begin
                        lvl_n = lvl | arrow_mask(byte_data);
                        cs_n  = C_IDLE;
                    end
                end
                C_BRK: cs_n = C_IDLE;
                C_EXTBRK: begin
                    lvl_n = lvl & ~arrow_mask(byte_data);
                    cs_n  = C_IDLE;
                end
                default: cs_n = C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs  <= C_IDLE;
            lvl <= 4'b0000;
            pls <= 4'b0000;
        end else begin
            cs  <= cs_n;
            lvl <= lvl_n;
            pls <= lvl_n & ~lvl;
        end
    end

    assign {up, down, left, right}         = lvl;
    assign {up_p, down_p, left_p, right_p} = pls;

endmodule

// File: tb/tb_ps2_arrow_keys.sv
// tb_ps2_arrow_keys: randomized PS/2 keystroke bench with a byte-level
// key-state reference model.
module tb_ps2_arrow_keys;

    localparam int H  = 30;
    localparam int FL = 8;
    localparam int TO = 600;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       up, down, left, right;
    logic       up_p, down_p, left_p, right_p;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    int         nbytes = 0;
    int         nerrs = 0;
    logic [7:0] last_b = 8'h00;
    int         dp[4];
    logic       bv_prev = 1'b0;
    logic [3:0] lv_prev = 4'b0000;

    logic [3:0] m_lvl = 4'b0000;
    int         m_p[4];
    bit         m_ext = 0;
    bit         m_brk = 0;
    int         m_nb = 0;
    int         m_ne = 0;

    always #20 clk = ~clk;

    ps2_arrow_keys #(
        .CLK_FREQ   (25000000),
        .FILTER_LEN (FL),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .up_p      (up_p),
        .down_p    (down_p),
        .left_p    (left_p),
        .right_p   (right_p),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    initial begin
        for (int i = 0; i < 4; i++) begin
            dp[i]  = 0;
            m_p[i] = 0;
        end
    end

    // Pulses must coincide with a rising level, one cycle after byte_valid.
    always @(negedge clk) begin
        logic [3:0] pv, lv;
        pv = {up_p, down_p, left_p, right_p};
        lv = {up, down, left, right};
        if (reset) begin
            if (byte_valid) begin
                nbytes++;
                last_b = byte_data;
            end
            if (frame_err) nerrs++;
            if (pv != 4'b0000) begin
                checks++;
                if ((pv & ~lv) != 0 || (pv & lv_prev) != 0 || !bv_prev) begin
                    errors++;
                    $display("FAIL pulse_timing: pulses=%b levels=%b prev=%b bv_prev=%b, required rising level after byte_valid",
                             pv, lv, lv_prev, bv_prev);
                end
            end
            for (int i = 0; i < 4; i++) if (pv[3-i]) dp[i]++;
        end
        bv_prev = byte_valid;
        lv_prev = lv;
    end

    function automatic int key_idx(input logic [7:0] b);
        case (b)
            8'h75:   return 0;
            8'h72:   return 1;
            8'h6B:   return 2;
            8'h74:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int k;
        k = key_idx(b);
        m_nb++;
        if (m_brk) begin
            if (m_ext && k >= 0) m_lvl[3-k] = 1'b0;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (m_ext && k >= 0) begin
                if (!m_lvl[3-k]) m_p[k]++;
                m_lvl[3-k] = 1'b1;
            end
            m_ext = 0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_bad,
                              input bit stop, input int n);
        logic [10:0] fr;
        fr = {stop, (~^b) ^ par_bad, b, 1'b0};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11);
        model_byte(b);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({up, down, left, right, up_p, down_p, left_p, right_p} !== 8'h00) begin
            errors++;
            $display("FAIL reset_keys: got %b required 00000000",
                     {up, down, left, right, up_p, down_p, left_p, right_p});
        end
        checks++;
        if ({byte_valid, frame_err, byte_data} !== 10'h000) begin
            errors++;
            $display("FAIL reset_rx: got %h required 000", {byte_valid, frame_err, byte_data});
        end
        reset = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (nerrs != 0 || nbytes != 0) begin
            errors++;
            $display("FAIL reset_quiet: bytes=%0d errs=%0d required 0 0", nbytes, nerrs);
        end
    endtask

    task automatic test_make_break;
        send_byte(8'hE0);
        send_byte(8'h75);
        checks++;
        if ({up, down, left, right} !== m_lvl || m_lvl !== 4'b1000) begin
            errors++;
            $display("FAIL up_make: got %b required %b", {up, down, left, right}, m_lvl);
        end
        checks++;
        if (dp[0] != 1) begin
            errors++;
            $display("FAIL up_pulse: got %0d pulses required 1", dp[0]);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++;
        if ({up, down, left, right} !== m_lvl) begin
            errors++;
            $display("FAIL up_break: got %b required %b", {up, down, left, right}, m_lvl);
        end
        checks++;
        if (dp[0] != m_p[0]) begin
            errors++;
            $display("FAIL up_break_pulse: got %0d required %0d", dp[0], m_p[0]);
        end
    endtask

    task automatic test_typematic;
        repeat (2) begin
            send_byte(8'hE0);
            send_byte(8'h6B);
        end
        checks++;
        if (left !== 1'b1 || dp[2] != 1 || dp[2] != m_p[2]) begin
            errors++;
            $display("FAIL typematic_left: level=%b pulses=%0d required 1 and 1", left, dp[2]);
        end
        send_byte(8'hE0);
        send_byte(8'h74);
        checks++;
        if ({up, down, left, right} !== m_lvl || m_lvl !== 4'b0011) begin
            errors++;
            $display("FAIL left_right: got %b required %b", {up, down, left, right}, m_lvl);
        end
    endtask

    task automatic test_plain_break;
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++;
        if (up !== 1'b1 || {up, down, left, right} !== m_lvl) begin
            errors++;
            $display("FAIL plain_break: got %b required %b", {up, down, left, right}, m_lvl);
        end
        send_byte(8'h1C);
        checks++;
        if (last_b !== 8'h1C || byte_data !== 8'h1C || nbytes != m_nb) begin
            errors++;
            $display("FAIL plain_byte: data=%h bytes=%0d required 1c %0d", byte_data, nbytes, m_nb);
        end
        checks++;
        if ({up, down, left, right} !== m_lvl) begin
            errors++;
            $display("FAIL plain_levels: got %b required %b", {up, down, left, right}, m_lvl);
        end
    endtask

    task automatic test_timeout;
        send_frame(8'h5A, 1'b0, 1'b1, 5);
        repeat (TO / 2) @(negedge clk);
        checks++;
        if (nerrs != m_ne) begin
            errors++;
            $display("FAIL timeout_early: errs=%0d required %0d", nerrs, m_ne);
        end
        repeat (TO) @(negedge clk);
        m_ne++;
        checks++;
        if (nerrs != m_ne) begin
            errors++;
            $display("FAIL timeout_err: errs=%0d required %0d", nerrs, m_ne);
        end
        send_byte(8'hE0);
        checks++;
        if (last_b !== 8'hE0 || nbytes != m_nb || nerrs != m_ne) begin
            errors++;
            $display("FAIL timeout_recover: data=%h bytes=%0d errs=%0d required e0 %0d %0d",
                     last_b, nbytes, nerrs, m_nb, m_ne);
        end
    endtask

    task automatic test_glitch_parity;
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4 * H) @(negedge clk);
        checks++;
        if (nerrs != m_ne || nbytes != m_nb) begin
            errors++;
            $display("FAIL glitch: errs=%0d bytes=%0d required %0d %0d", nerrs, nbytes, m_ne, m_nb);
        end
        send_frame(8'h75, 1'b1, 1'b1, 11);
`ifdef PS2_PARITY_CHK_EN
        m_ne++;
`else
        model_byte(8'h75);
`endif
        checks++;
        if (nerrs != m_ne || nbytes != m_nb || {up, down, left, right} !== m_lvl) begin
            errors++;
            $display("FAIL parity: errs=%0d bytes=%0d lv=%b required %0d %0d %b",
                     nerrs, nbytes, {up, down, left, right}, m_ne, m_nb, m_lvl);
        end
        checks++;
        if (last_b !== 8'hE0 && last_b !== 8'h75) begin
            errors++;
            $display("FAIL parity_data: got %h", last_b);
        end
    endtask

    task automatic test_random;
        logic [7:0] pool [7];
        logic [7:0] b;
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C};
        for (int n = 0; n < 30; n++) begin
            b = pool[$urandom_range(6, 0)];
            if ($urandom_range(7, 0) == 0) begin
                send_frame(b, 1'b0, 1'b0, 11);
                m_ne++;
            end else begin
                send_byte(b);
            end
            checks++;
            if ({up, down, left, right} !== m_lvl || nbytes != m_nb || nerrs != m_ne) begin
                errors++;
                $display("FAIL random_%0d: lv=%b bytes=%0d errs=%0d required %b %0d %0d",
                         n, {up, down, left, right}, nbytes, nerrs, m_lvl, m_nb, m_ne);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dp[i] != m_p[i]) begin
                errors++;
                $display("FAIL random_pulses_%0d: got %0d required %0d", i, dp[i], m_p[i]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        send_byte(8'hE0);
        send_byte(8'h6B);
        send_frame(8'h33, 1'b0, 1'b1, 5);
        @(negedge clk);
        reset = 1'b0;
        m_lvl = 4'b0000;
        m_ext = 0;
        m_brk = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({up, down, left, right, up_p, down_p, left_p, right_p,
             byte_valid, frame_err, byte_data} !== 18'h0) begin
            errors++;
            $display("FAIL midframe_reset: lv=%b data=%h required 0000 00",
                     {up, down, left, right}, byte_data);
        end
        reset = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'hE0);
        send_byte(8'h72);
        checks++;
        if ({up, down, left, right} !== m_lvl || m_lvl !== 4'b0100 || last_b !== 8'h72) begin
            errors++;
            $display("FAIL after_reset: lv=%b data=%h required %b 72",
                     {up, down, left, right}, last_b, m_lvl);
        end
        checks++;
        if (dp[1] != m_p[1] || nerrs != m_ne) begin
            errors++;
            $display("FAIL after_reset_pulse: got %0d errs=%0d required %0d %0d",
                     dp[1], nerrs, m_p[1], m_ne);
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_typematic();
        test_plain_break();
        test_timeout();
        test_glitch_parity();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
